// File: rtl/taskwait_client_pkg.sv
// Shared definitions for the taskwait protocol between accelerator and manager.
// Header beat layout (type bit, components field) and the wake-up payload
// constant must match the manager side exactly.
package taskwait_client_pkg;

  // Header beat layout, shared with the Taskwait manager.
  localparam int TYPE_B                = 8;
  localparam int INSTREAM_COMPONENTS_L = 32;
  localparam int INSTREAM_COMPONENTS_H = 63;

  // Payload of the manager's wake-up beat.
  localparam logic [63:0] TW_WAKEUP_DATA = 64'd1;

  localparam int CHILD_CNT_W = INSTREAM_COMPONENTS_H - INSTREAM_COMPONENTS_L + 1;

  // Saturating increment of the child counter.
  function automatic logic [CHILD_CNT_W-1:0] sat_inc(input logic [CHILD_CNT_W-1:0] v);
    sat_inc = (v == {CHILD_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/taskwait_client.sv
// Purpose: accelerator-side taskwait initiator; counts children, sends header+task id, waits for wake-up.
// Latency: tw_req -> header beat next cycle -> TID beat -> wait; tw_done one cycle after wake-up (or after tw_req on the empty skip path).
// Backpressure: outStream beats held stable until TREADY; inStream accepted only while waiting for wake-up.
// Ports: clk/rst (sync, active-high); child_created pulse; tw_req/tw_task_id/tw_req_ready request side;
//        tw_done pulse, protocol_err sticky; outStream_* two-beat message to manager; inStream_* wake-up beat.
module taskwait_client
  import taskwait_client_pkg::*;
#(
  parameter int MAX_ACCS   = 16,
  parameter int ACC_ID     = 0,
  parameter int SKIP_EMPTY = 1,
  localparam int ACC_BITS  = $clog2(MAX_ACCS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                child_created,
  input  logic                tw_req,
  input  logic [63:0]         tw_task_id,
  output logic                tw_req_ready,
  output logic                tw_done,
  output logic                protocol_err,
  output logic [63:0]         outStream_TDATA,
  output logic                outStream_TVALID,
  input  logic                outStream_TREADY,
  output logic [ACC_BITS-1:0] outStream_TID,
  input  logic [63:0]         inStream_TDATA,
  input  logic                inStream_TVALID,
  output logic                inStream_TREADY
);

  localparam logic [2:0] IDLE        = 3'd0;
  localparam logic [2:0] SEND_HEADER = 3'd1;
  localparam logic [2:0] SEND_TID    = 3'd2;
  localparam logic [2:0] WAIT_WAKEUP = 3'd3;
  localparam logic [2:0] DONE        = 3'd4;

  logic [2:0]             state;
  logic [CHILD_CNT_W-1:0] child_cnt;
  logic [CHILD_CNT_W-1:0] comps;
  logic [63:0]            task_id;
  logic [CHILD_CNT_W-1:0] cnt_plus;
  logic                   hdr_fire;
  logic [63:0]            hdr_beat;

  // Counter value including a child created this very cycle.
  assign cnt_plus = child_created ? sat_inc(child_cnt) : child_cnt;
  assign hdr_fire = (state == SEND_HEADER) && outStream_TREADY;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      child_cnt    <= '0;
      comps        <= '0;
      task_id      <= '0;
      protocol_err <= 1'b0;
    end else begin
      // Once the header carrying the snapshot is accepted the count restarts;
      // a child created on that same cycle belongs to the next taskwait.
      child_cnt <= hdr_fire ? {{(CHILD_CNT_W-1){1'b0}}, child_created} : cnt_plus;

      case (state)
        IDLE: begin
          if (tw_req) begin
            task_id <= tw_task_id;
            comps   <= cnt_plus;
            if ((SKIP_EMPTY != 0) && (cnt_plus == '0)) begin
              state <= DONE;
            end else begin
              state <= SEND_HEADER;
            end
          end
        end
        SEND_HEADER: begin
          if (outStream_TREADY) begin
            state <= SEND_TID;
          end
        end
        SEND_TID: begin
          if (outStream_TREADY) begin
            state <= WAIT_WAKEUP;
          end
        end
        WAIT_WAKEUP: begin
          if (inStream_TVALID) begin
            if (inStream_TDATA != TW_WAKEUP_DATA) begin
              protocol_err <= 1'b1;
            end
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    hdr_beat = '0;
    hdr_beat[TYPE_B] = 1'b1;
    hdr_beat[INSTREAM_COMPONENTS_H:INSTREAM_COMPONENTS_L] = comps;
  end

  // All outputs decode registered state only; inStream never reaches outStream combinationally.
  assign tw_req_ready     = (state == IDLE);
  assign tw_done          = (state == DONE);
  assign outStream_TVALID = (state == SEND_HEADER) || (state == SEND_TID);
  assign outStream_TDATA  = (state == SEND_TID) ? task_id : hdr_beat;
  assign outStream_TID    = ACC_BITS'(ACC_ID);
  assign inStream_TREADY  = (state == WAIT_WAKEUP);

endmodule

// File: tb/tb_taskwait_client.sv
// Randomized bench for taskwait_client: two instances (skip-empty on and off)
// share one random input stream and are each compared every cycle against a
// transaction-level model of the taskwait protocol.
module tb_taskwait_client;
  import taskwait_client_pkg::*;

  localparam int NCYC = 4000;

  logic        clk = 1'b0;
  logic        rst;
  logic        child_created;
  logic        tw_req;
  logic [63:0] tw_task_id;
  logic        trdy;
  logic [63:0] in_dat;
  logic        in_vld;

  logic        o_ready [2];
  logic        o_done  [2];
  logic        o_perr  [2];
  logic [63:0] o_dat   [2];
  logic        o_vld   [2];
  logic [3:0]  o_tid   [2];
  logic        o_irdy  [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    taskwait_client #(
      .MAX_ACCS   (16),
      .ACC_ID     ((g == 0) ? 5 : 3),
      .SKIP_EMPTY ((g == 0) ? 1 : 0)
    ) u_dut (
      .clk              (clk),
      .rst              (rst),
      .child_created    (child_created),
      .tw_req           (tw_req),
      .tw_task_id       (tw_task_id),
      .tw_req_ready     (o_ready[g]),
      .tw_done          (o_done[g]),
      .protocol_err     (o_perr[g]),
      .outStream_TDATA  (o_dat[g]),
      .outStream_TVALID (o_vld[g]),
      .outStream_TREADY (trdy),
      .outStream_TID    (o_tid[g]),
      .inStream_TDATA   (in_dat),
      .inStream_TVALID  (in_vld),
      .inStream_TREADY  (o_irdy[g])
    );
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // A taskwait is a list of pending outbound beats followed by a wait for
  // one wake-up beat and a single done cycle.
  bit          skip_cfg [2] = '{1'b1, 1'b0};
  int          accid_cfg[2] = '{5, 3};
  logic [63:0] m_children[2];
  bit          m_busy [2];
  bit          m_wait [2];
  bit          m_done [2];
  bit          m_perr [2];
  bit          m_hpend[2];
  bit          m_tpend[2];
  logic [63:0] m_hdr  [2];
  logic [63:0] m_id   [2];

  function automatic logic [63:0] sat32(input logic [63:0] x);
    sat32 = (x > 64'h0000_0000_FFFF_FFFF) ? 64'h0000_0000_FFFF_FFFF : x;
  endfunction

  function automatic logic [63:0] mk_hdr(input logic [63:0] c);
    logic [63:0] h;
    h = '0;
    h[TYPE_B] = 1'b1;
    h[INSTREAM_COMPONENTS_H:INSTREAM_COMPONENTS_L] = c[31:0];
    return h;
  endfunction

  task automatic model_step(input int i);
    logic [63:0] sum;
    bit idle, hdr_acc;
    if (rst) begin
      m_children[i] = 0; m_busy[i] = 0; m_wait[i] = 0; m_done[i] = 0;
      m_perr[i] = 0; m_hpend[i] = 0; m_tpend[i] = 0;
      return;
    end
    sum     = sat32(m_children[i] + 64'(child_created));
    hdr_acc = m_hpend[i] && trdy;
    idle    = !m_busy[i] && !m_done[i];
    if (m_done[i]) begin
      m_done[i] = 0;
      m_busy[i] = 0;
    end else if (idle) begin
      if (tw_req) begin
        if (skip_cfg[i] && sum == 0) begin
          m_done[i] = 1;
        end else begin
          m_busy[i] = 1; m_hpend[i] = 1; m_tpend[i] = 1;
          m_hdr[i] = mk_hdr(sum);
          m_id[i]  = tw_task_id;
        end
      end
    end else if (m_hpend[i] || m_tpend[i]) begin
      if (trdy) begin
        if (m_hpend[i]) m_hpend[i] = 0;
        else begin
          m_tpend[i] = 0;
          m_wait[i]  = 1;
        end
      end
    end else if (m_wait[i] && in_vld) begin
      m_wait[i] = 0;
      if (in_dat != 64'd1) m_perr[i] = 1;
      m_done[i] = 1;
    end
    m_children[i] = hdr_acc ? 64'(child_created) : sum;
  endtask

  task automatic check_outputs(input int i);
    bit vld_exp;
    vld_exp = m_hpend[i] || m_tpend[i];
    check_eq($sformatf("d%0d_ready", i), 64'(o_ready[i]), 64'(!m_busy[i] && !m_done[i]));
    check_eq($sformatf("d%0d_done", i),  64'(o_done[i]),  64'(m_done[i]));
    check_eq($sformatf("d%0d_perr", i),  64'(o_perr[i]),  64'(m_perr[i]));
    check_eq($sformatf("d%0d_vld", i),   64'(o_vld[i]),   64'(vld_exp));
    check_eq($sformatf("d%0d_irdy", i),  64'(o_irdy[i]),  64'(m_wait[i]));
    check_eq($sformatf("d%0d_tid", i),   64'(o_tid[i]),   64'(accid_cfg[i]));
    if (vld_exp) begin
      check_eq($sformatf("d%0d_dat", i), o_dat[i], m_hpend[i] ? m_hdr[i] : m_id[i]);
    end
  endtask

  // ---------------- stimulus ----------------
  int child_pct;
  int trdy_pct;

  initial begin
    rst = 1'b1; child_created = 1'b0; tw_req = 1'b0; tw_task_id = '0;
    trdy = 1'b0; in_dat = '0; in_vld = 1'b0;
    child_pct = 0; trdy_pct = 60;
    for (int i = 0; i < 2; i++) model_step(i);
    @(posedge clk);
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      #1;
      for (int i = 0; i < 2; i++) check_outputs(i);
      if (cyc % 250 == 0) begin
        case ($urandom_range(0, 2))
          0: child_pct = 0;
          1: child_pct = 10;
          default: child_pct = 40;
        endcase
        trdy_pct = ($urandom_range(0, 1) == 0) ? 15 : 70;
      end
      rst           = ($urandom_range(0, 199) == 0);
      child_created = ($urandom_range(0, 99) < child_pct);
      tw_req        = ($urandom_range(0, 4) == 0);
      tw_task_id    = {$urandom, $urandom};
      trdy          = ($urandom_range(0, 99) < trdy_pct);
      in_vld        = ($urandom_range(0, 9) < 3);
      case ($urandom_range(0, 9))
        0:       in_dat = 64'd5;
        1:       in_dat = {$urandom, $urandom};
        default: in_dat = 64'd1;
      endcase
      for (int i = 0; i < 2; i++) model_step(i);
      @(posedge clk);
    end
    #1;
    for (int i = 0; i < 2; i++) check_outputs(i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
